reg_dump_reader: RTL

Read-side companion to the multi-cycle CPU register file: on request, halts the core, walks all 32 general registers through one register-file read port, and streams each `(index, value)` pair out over a valid/ready interface to the debug host link. It releases the core and pulses `done` when the last register has been accepted. It sits between the CPU control unit (halt handshake), the register file read port, and the debug transmitter.

---
 rtl/reg_dump_reader_pkg.sv | 16 +
 rtl/reg_dump_reader.sv | 94 +++++++++
 2 files changed

// File: rtl/reg_dump_reader_pkg.sv
// Shared CPU constants and the dump FSM state type.
package reg_dump_reader_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ADDR,
        SEND,
        DONE
    } dump_state_t;

endpackage

// File: rtl/reg_dump_reader.sv
// Halts the core, walks every general register through one read port and
// streams (index, value) beats to the debug link, then releases the core.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int NUM_REGS = REG_COUNT,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DATA_W   = REG_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              halt_req,
    input  logic              halt_ack,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_t       state;
    logic [ADDR_W-1:0] index;

    // Read address follows the index counter in every state.
    assign rd_addr = index;

    // Dump FSM with index counter and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            index     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            halt_req  <= 1'b0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= HALT;
                        index    <= '0;
                        busy     <= 1'b1;
                        halt_req <= 1'b1;
                    end
                end
                HALT: begin
                    if (halt_ack) begin
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    // Capture only while the core is frozen; otherwise pause here.
                    if (halt_ack) begin
                        out_data  <= rd_data;
                        out_index <= index;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // Terminal compare precedes the increment so the counter never wraps.
                        if (index == LAST_IDX) begin
                            state    <= DONE;
                            halt_req <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                            state <= ADDR;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
